dma_axi_mem_slave: RTL
======================

// Module: dma_axi_mem_slave
// PURPOSE
// AXI4 memory responder: the target end of the DMA master AXI interface. Serves the
// AR/R and AW/W/B channels from an internal word-addressed RAM with independent read
// and write FSMs. Used as the DMA source/destination memory in simulation and FPGA
// bring-up. Supports INCR/FIXED bursts and flags protocol or address errors via SLVERR.
// PARAMETERS
// ADDR_WIDTH  32    AXI address width
// DATA_WIDTH  32    AXI data width (32 or 64); STRB = DATA_WIDTH/8
// ID_WIDTH    8     AXI ID width
// MEM_WORDS   4096  RAM depth in DATA_WIDTH words (power of 2); base address 0
// PORTS
// clk      in   1           clock
// rst      in   1           asynchronous reset, active-high
// awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address
// awvalid  in   1 ; awready  out  1
// wdata/wstrb/wlast  in  DATA/STRB/1  write data
// wvalid   in   1 ; wready   out  1
// bid/bresp  out  ID/2  write response
// bvalid   out  1 ; bready   in   1
// arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address
// arvalid  in   1 ; arready  out  1
// rid/rdata/rresp/rlast  out  ID/DATA/2/1  read data
// rvalid   out  1 ; rready   in   1
// BEHAVIOUR
// - Reset: all ready/valid outputs 0, bid/bresp/rid/rdata/rresp/rlast 0, FSMs to IDLE.
//   RAM contents are not reset. awready/arready rise on the first clk edge after rst drops.
// - Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE. awready=1 only in W_IDLE; AW handshake
//   latches id/addr/len/size/burst, clears beat count and err flag. wready=1 only in W_DATA.
// - Each W beat writes the bytes enabled by wstrb at word addr[OFF+log2(MEM_WORDS)-1:OFF],
//   where OFF=log2(STRB). INCR: addr += 1<<size. FIXED: addr is held.
// - Burst end: beat count == awlen. Go to W_RESP, bvalid=1 next cycle, bid=latched id.
//   Hold bvalid/bid/bresp until bready; return to W_IDLE the cycle after the B handshake.
// - Write err flag (bresp=2'b10 SLVERR, otherwise OKAY) is set by any of:
//   - wlast not matching the final beat (the burst still ends on count == awlen);
//   - awburst=WRAP/reserved, or awsize > log2(STRB);
//   - beat address >= MEM_WORDS*STRB.
//   Errored beats do not write RAM; later in-range beats of the same burst still write.
// - Read FSM R_IDLE->R_DATA->R_IDLE. arready=1 only in R_IDLE. The first rvalid comes
//   1 cycle after the AR handshake (synchronous RAM read). With rready held high, one
//   beat per cycle. rlast=1 on beat arlen. rid=latched arid.
// - R outputs are stable while rvalid&&!rready. Address/beat count advance only on an R
//   handshake. After the last-beat handshake, go to R_IDLE.
// - Read err rules match the write rules. An errored beat returns rdata=0 and rresp=SLVERR;
//   in-range beats return OKAY.
// - Read and write channels are fully concurrent. A same-word read and write in one cycle:
//   the read returns old data (read-before-write).
// - An AW or AR presented while its FSM is busy stalls (ready=0); no outstanding queue.
// - Reset asserted mid-burst aborts the burst immediately. No B/R is issued for it.
// - awlen/arlen=255 (256 beats) is supported. INCR address wraps modulo 2^ADDR_WIDTH.
//   The 4KB-boundary rule is not checked.
// TESTING
// 1. AW addr=0x100 len=3 size=2 INCR, 4 W beats 0xA0..0xA3 strb=F, last on beat 3
//    -> bresp=OKAY, bid=awid. AR same -> 4 R beats 0xA0..0xA3, rlast on beat 3 only.
// 2. Write 0x11223344 @0x40, then strb=0x2 data 0x0000FF00 @0x40 -> read 0x1122FF44.
// 3. AR addr=MEM_WORDS*4-8 len=3 INCR -> beats 0,1 OKAY with RAM data;
//    beats 2,3 rresp=SLVERR and rdata=0.
// 4. W burst len=1 with wlast on beat 0 -> bresp=SLVERR; both beats written.
//    awburst=WRAP -> SLVERR and RAM unchanged.
// 5. Read len=7 with random rready stalls (50%) and concurrent write bursts
//    -> rdata stable while stalled, data order intact, B and R both complete.
// 6. Assert rst during beat 2 of an 8-beat write -> bvalid=0 and all readies 0 in reset;
//    a new AW is accepted 1 cycle after release.

Source files
------------

// File: rtl/dma_axi_mem_slave.sv
// AXI4 memory responder backed by a word-addressed RAM, with independent read and write FSMs.
// INCR/FIXED bursts are served; WRAP/reserved bursts, oversize beats and out-of-range beats answer SLVERR.
module dma_axi_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int MW     = $clog2(MEM_WORDS);
  localparam int HI_W   = ADDR_WIDTH - OFF - MW;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic beat_err_f(input logic [HI_W-1:0] addr_hi, input logic [2:0] size,
                                      input logic [1:0] burst);
    return burst[1] || (size > 3'(OFF)) || (|addr_hi);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr_f(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size, input logic [1:0] burst);
    if (burst == BURST_FIXED) return addr;
    else return addr + (ADDR_WIDTH'(1) << size);
  endfunction

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   aw_id_q, aw_id_d, bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]            aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]            aw_size_q, aw_size_d;
  logic [1:0]            aw_burst_q, aw_burst_d, bresp_q, bresp_d;
  logic                  w_err_q, w_err_d, awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                  w_fire_s, w_beat_err_s, w_last_beat_s, w_mem_we_s;
  logic [MW-1:0]         w_idx_s;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]            ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]            ar_size_q, ar_size_d, r_ld_size_s;
  logic [1:0]            ar_burst_q, ar_burst_d, r_ld_burst_s, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rlast_q, rlast_d, rvalid_q, rvalid_d, arready_q, arready_d, r_ld_s;
  logic [ADDR_WIDTH-1:OFF] r_ld_addr_s;

  assign w_fire_s      = wvalid && wready_q;
  assign w_beat_err_s  = beat_err_f(aw_addr_q[ADDR_WIDTH-1:OFF+MW], aw_size_q, aw_burst_q);
  assign w_last_beat_s = (w_cnt_q == aw_len_q);
  assign w_mem_we_s    = w_fire_s && !w_beat_err_s;
  assign w_idx_s       = aw_addr_q[OFF+MW-1:OFF];

  // Write FSM: the burst ends on beat count, a wlast mismatch only taints the response.
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          w_state_d  = W_DATA;
          aw_id_d    = awid;
          aw_addr_d  = awaddr;
          aw_len_d   = awlen;
          aw_size_d  = awsize;
          aw_burst_d = awburst;
          w_cnt_d    = 8'd0;
          w_err_d    = 1'b0;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_fire_s) begin
          if (w_beat_err_s || (wlast != w_last_beat_s)) w_err_d = 1'b1;
          else w_err_d = w_err_q;
          if (w_last_beat_s) begin
            w_state_d = W_RESP;
            bid_d     = aw_id_q;
            bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
          end else begin
            aw_addr_d = next_addr_f(aw_addr_q, aw_size_q, aw_burst_q);
            w_cnt_d   = w_cnt_q + 8'd1;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) w_state_d = W_IDLE;
        else w_state_d = W_RESP;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read FSM: the next beat's word is fetched on the handshake that retires the current one.
  always_comb begin
    r_state_d    = r_state_q;
    rd_addr_d    = rd_addr_q;
    ar_len_d     = ar_len_q;
    ar_size_d    = ar_size_q;
    ar_burst_d   = ar_burst_q;
    r_cnt_d      = r_cnt_q;
    rid_d        = rid_q;
    rlast_d      = rlast_q;
    r_ld_s       = 1'b0;
    r_ld_addr_s  = rd_addr_q[ADDR_WIDTH-1:OFF];
    r_ld_size_s  = ar_size_q;
    r_ld_burst_s = ar_burst_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          r_state_d    = R_DATA;
          rd_addr_d    = araddr;
          ar_len_d     = arlen;
          ar_size_d    = arsize;
          ar_burst_d   = arburst;
          rid_d        = arid;
          r_cnt_d      = 8'd0;
          rlast_d      = (arlen == 8'd0);
          r_ld_s       = 1'b1;
          r_ld_addr_s  = araddr[ADDR_WIDTH-1:OFF];
          r_ld_size_s  = arsize;
          r_ld_burst_s = arburst;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            rd_addr_d   = next_addr_f(rd_addr_q, ar_size_q, ar_burst_q);
            r_cnt_d     = r_cnt_q + 8'd1;
            rlast_d     = (r_cnt_d == ar_len_q);
            r_ld_s      = 1'b1;
            r_ld_addr_s = rd_addr_d[ADDR_WIDTH-1:OFF];
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_ld_s) begin
      if (beat_err_f(r_ld_addr_s[ADDR_WIDTH-1:OFF+MW], r_ld_size_s, r_ld_burst_s)) begin
        rdata_d = {DATA_WIDTH{1'b0}};
        rresp_d = RESP_SLVERR;
      end else begin
        rdata_d = mem[r_ld_addr_s[OFF+MW-1:OFF]];
        rresp_d = RESP_OKAY;
      end
    end else begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // RAM write port; the read side samples the array on the same edge, so it sees old data.
  always_ff @(posedge clk) begin
    if (w_mem_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx_s][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // State and output registers; reset drops any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= {ID_WIDTH{1'b0}};
      aw_addr_q  <= {ADDR_WIDTH{1'b0}};
      aw_len_q   <= 8'd0;
      aw_size_q  <= 3'd0;
      aw_burst_q <= 2'd0;
      w_cnt_q    <= 8'd0;
      w_err_q    <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= {ID_WIDTH{1'b0}};
      bresp_q    <= 2'd0;
      r_state_q  <= R_IDLE;
      rd_addr_q  <= {ADDR_WIDTH{1'b0}};
      ar_len_q   <= 8'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'd0;
      r_cnt_q    <= 8'd0;
      rid_q      <= {ID_WIDTH{1'b0}};
      rdata_q    <= {DATA_WIDTH{1'b0}};
      rresp_q    <= 2'd0;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      r_state_q  <= r_state_d;
      rd_addr_q  <= rd_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      rid_q      <= rid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
      rvalid_q   <= rvalid_d;
      arready_q  <= arready_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule
